qos_wrr_arbiter: RTL and testbench



---
 rtl/qos_pkg.sv | 15 +
 rtl/rr_pick.sv | 29 ++
 rtl/qos_wrr_arbiter.sv | 103 ++++++++++
 tb/tb_qos_wrr_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/qos_pkg.sv
// Shared constants and types for the QoS egress weighted round-robin arbiter.
package qos_pkg;
    localparam int NUM_CLASSES = 4;
    localparam int DATA_W      = 12;
    localparam int CLASS_MSB   = 11;
    localparam int CLASS_LSB   = 10;
    localparam int CNT_W       = 4;

    typedef logic [1:0] class_t;

    localparam int W_P0 = 4;
    localparam int W_P1 = 3;
    localparam int W_P2 = 2;
    localparam int W_P3 = 1;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requesting class at or after ptr, in cyclic order.
module rr_pick
    import qos_pkg::*;
(
    input  logic [3:0] req,
    input  class_t     ptr,
    output logic       gnt_valid,
    output class_t     gnt_idx
);
    logic [7:0] doubled;
    logic [3:0] rotated;
    class_t     offset;

    // Bit i of rotated is req[(ptr + i) mod 4].
    assign doubled = {req, req};
    assign rotated = doubled[ptr +: 4];

    always_comb begin
        offset = '0;
        for (int i = 3; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = class_t'(i);
            end
        end
    end

    assign gnt_valid = |req;
    assign gnt_idx   = ptr + offset;
endmodule

// File: rtl/qos_wrr_arbiter.sv
// Weighted round-robin drain of four class FIFOs into one downstream FIFO,
// with a single-word pop-to-push pipeline stage.
module qos_wrr_arbiter
    import qos_pkg::*;
#(
    parameter int DATA_W = qos_pkg::DATA_W,
    parameter int W0     = W_P0,
    parameter int W1     = W_P1,
    parameter int W2     = W_P2,
    parameter int W3     = W_P3,
    parameter int CNT_W  = qos_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DATA_W-1:0] fifo_data,
    input  logic [3:0]          emptyFIFO,
    input  logic                almost_full_out,
    output logic [3:0]          pop,
    output logic                push_out,
    output logic [DATA_W-1:0]   data_out,
    output class_t              grant_class,
    output logic                idle
);
    logic [3:0][CNT_W-1:0] weight;
    logic [3:0]            elig;
    logic                  stall;
    logic                  gnt_valid;
    logic                  grant;
    class_t                gnt_idx;
    class_t                next_class;
    logic [CNT_W-1:0]      eff;

    class_t                ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  valid_q;
    class_t                sel_q;

    class_t                init_ptr;
    logic [CNT_W-1:0]      init_cnt;
    logic                  init_found;

    assign weight = {CNT_W'(W3), CNT_W'(W2), CNT_W'(W1), CNT_W'(W0)};

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            elig[k] = !emptyFIFO[k] && (weight[k] != '0);
        end
    end

    // Reset starts at the first class that has a nonzero weight.
    always_comb begin
        init_ptr   = '0;
        init_cnt   = '0;
        init_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!init_found && weight[k] != '0) begin
                init_ptr   = class_t'(k);
                init_cnt   = weight[k];
                init_found = 1'b1;
            end
        end
    end

    rr_pick u_pick (
        .req       (elig),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign stall      = almost_full_out || reset;
    assign grant      = gnt_valid && !stall;
    assign pop        = grant ? (4'b0001 << gnt_idx) : 4'b0000;
    assign next_class = gnt_idx + 2'd1;
    // Leaving the current class forfeits its leftover credit.
    assign eff        = (gnt_idx == ptr) ? cnt : weight[gnt_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= init_ptr;
            cnt     <= init_cnt;
            valid_q <= 1'b0;
            sel_q   <= '0;
        end else begin
            valid_q <= grant;
            sel_q   <= gnt_idx;
            if (grant) begin
                if (eff <= CNT_W'(1)) begin
                    ptr <= next_class;
                    cnt <= weight[next_class];
                end else begin
                    ptr <= gnt_idx;
                    cnt <= eff - CNT_W'(1);
                end
            end
        end
    end

    assign push_out    = valid_q;
    assign data_out    = valid_q ? fifo_data[int'(sel_q)*DATA_W +: DATA_W] : '0;
    assign grant_class = valid_q ? sel_q : '0;
    assign idle        = (&emptyFIFO) && !valid_q;
endmodule

// File: tb/tb_qos_wrr_arbiter.sv
// Self-checking bench for qos_wrr_arbiter: table vectors, corner sequences and
// randomized traffic against a queue-based reference of the WRR policy.
module tb_qos_wrr_arbiter;
    import qos_pkg::*;

    typedef struct {
        logic rst;
        logic afull;
        int   exp_pop;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        almost_full_out;
    logic [47:0] fifo_data;
    logic [3:0]  emptyFIFO;
    logic [3:0]  pop;
    logic        push_out;
    logic [11:0] data_out;
    logic [1:0]  grant_class;
    logic        idle;

    logic        reset_b;
    logic        almost_full_b;
    logic [47:0] fifo_data_b;
    logic [3:0]  empty_b;
    logic [3:0]  pop_b;
    logic        push_b;
    logic [11:0] data_out_b;
    logic [1:0]  grant_class_b;
    logic        idle_b;

    int checks   = 0;
    int failures = 0;

    logic [11:0] q [4][$];
    int          wt [4] = '{4, 3, 2, 1};
    int          mptr;
    int          mcnt;
    logic        exp_valid;
    logic [11:0] exp_word;
    int          exp_cls;

    always #5 clk = ~clk;

    qos_wrr_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_data       (fifo_data),
        .emptyFIFO       (emptyFIFO),
        .almost_full_out (almost_full_out),
        .pop             (pop),
        .push_out        (push_out),
        .data_out        (data_out),
        .grant_class     (grant_class),
        .idle            (idle)
    );

    qos_wrr_arbiter #(.W1(0)) dut_w1 (
        .clk             (clk),
        .reset           (reset_b),
        .fifo_data       (fifo_data_b),
        .emptyFIFO       (empty_b),
        .almost_full_out (almost_full_b),
        .pop             (pop_b),
        .push_out        (push_b),
        .data_out        (data_out_b),
        .grant_class     (grant_class_b),
        .idle            (idle_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference policy: a current class and the grants it has left this turn.
    function automatic void modelReset();
        mptr = 0;
        mcnt = 0;
        for (int k = 3; k >= 0; k--) begin
            if (wt[k] != 0) begin
                mptr = k;
                mcnt = wt[k];
            end
        end
    endfunction

    function automatic int modelGrant(input logic rst, input logic afull);
        if (rst || afull) return -1;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (mptr + i) % 4;
            if (q[k].size() > 0 && wt[k] != 0) return k;
        end
        return -1;
    endfunction

    function automatic void modelCredit(input int g);
        int left;
        left = ((g == mptr) ? mcnt : wt[g]) - 1;
        if (left <= 0) begin
            mptr = (g + 1) % 4;
            mcnt = wt[mptr];
        end else begin
            mptr = g;
            mcnt = left;
        end
    endfunction

    function automatic logic [11:0] newWord(input int k);
        return {2'(k), 10'($urandom)};
    endfunction

    // One clock: drive at the falling edge, check, then move queues and model.
    task automatic applyStimulus(input logic rst, input logic afull, input int tbl);
        int         g;
        logic       all_empty;
        logic [3:0] exp_pop;
        reset           = rst;
        almost_full_out = afull;
        for (int k = 0; k < 4; k++) emptyFIFO[k] = (q[k].size() == 0);
        all_empty = &emptyFIFO;
        #1;
        g       = modelGrant(rst, afull);
        exp_pop = (g >= 0) ? 4'(32'd1 << g) : 4'b0000;
        checkOutput("pop", 32'(pop), 32'(exp_pop));
        if (tbl != -2) checkOutput("pop_table", 32'(pop), (tbl < 0) ? 32'd0 : (32'd1 << tbl));
        checkOutput("push_out", 32'(push_out), 32'(exp_valid));
        checkOutput("data_out", 32'(data_out), exp_valid ? 32'(exp_word) : 32'd0);
        checkOutput("grant_class", 32'(grant_class), exp_valid ? 32'(exp_cls) : 32'd0);
        checkOutput("idle", 32'(idle), 32'(all_empty && !exp_valid));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            exp_word = q[g].pop_front();
            fifo_data[g*12 +: 12] = exp_word;
            exp_valid = 1'b1;
            exp_cls   = g;
            modelCredit(g);
        end else begin
            exp_valid = 1'b0;
        end
        if (rst) modelReset();
        @(negedge clk);
    endtask

    task automatic clearQueues();
        for (int k = 0; k < 4; k++) q[k].delete();
    endtask

    task automatic fillClass(input int k, input int n);
        for (int i = 0; i < n; i++) q[k].push_back(newWord(k));
    endtask

    initial begin
        vec_t tblA [20];
        int   seqA [20] = '{0,0,0,0,1,1,1,2,2,3,0,-1,-1,-1,-1,-1,0,0,0,1};
        int   seqB [5]  = '{2,2,2,-1,-1};
        int   seqC [6]  = '{0,0,1,1,1,2};
        int   seqD [8]  = '{0,0,-1,0,0,0,0,1};
        int   seqW [9]  = '{0,0,0,0,2,2,3,0,0};

        for (int i = 0; i < 20; i++) begin
            tblA[i].rst     = 1'b0;
            tblA[i].afull   = (i >= 11 && i <= 15);
            tblA[i].exp_pop = seqA[i];
        end

        reset = 1'b1; almost_full_out = 1'b0; fifo_data = '0; emptyFIFO = 4'hF;
        reset_b = 1'b1; almost_full_b = 1'b0; empty_b = 4'hF; fifo_data_b = '0;
        for (int k = 0; k < 4; k++) fifo_data_b[k*12 +: 12] = {2'(k), 10'(k + 5)};
        repeat (2) @(posedge clk);
        @(negedge clk);
        modelReset();
        exp_valid = 1'b0;
        exp_word  = '0;
        exp_cls   = 0;

        // Default weights, full FIFOs, then a five-cycle stall mid-burst.
        for (int k = 0; k < 4; k++) fillClass(k, 10);
        for (int i = 0; i < 20; i++) applyStimulus(tblA[i].rst, tblA[i].afull, tblA[i].exp_pop);

        clearQueues();
        applyStimulus(1'b1, 1'b0, -1);
        fillClass(2, 3);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, seqB[i]);

        // Class 0 runs dry while it still holds credit.
        clearQueues();
        applyStimulus(1'b1, 1'b0, -1);
        fillClass(0, 2); fillClass(1, 3); fillClass(2, 4);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, seqC[i]);

        // Reset right after a pop drops the in-flight word.
        clearQueues();
        applyStimulus(1'b1, 1'b0, -1);
        for (int k = 0; k < 4; k++) fillClass(k, 8);
        for (int i = 0; i < 8; i++) applyStimulus(i == 2, 1'b0, seqD[i]);

        clearQueues();
        applyStimulus(1'b1, 1'b0, -1);
        for (int k = 0; k < 4; k++) fillClass(k, 2);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(0, 3);
                if (q[k].size() < 6) q[k].push_back(newWord(k));
            end
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, -2);
        end
        clearQueues();
        applyStimulus(1'b0, 1'b0, -2);
        applyStimulus(1'b0, 1'b0, -2);

        // Class 1 masked by a zero weight, all FIFOs always nonempty.
        empty_b = 4'h0;
        @(negedge clk);
        reset_b = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1;
            checkOutput("w1_pop", 32'(pop_b), 32'd1 << seqW[i]);
            checkOutput("w1_push", 32'(push_b), 32'(i > 0));
            if (i > 0) begin
                checkOutput("w1_class", 32'(grant_class_b), 32'(seqW[i-1]));
                checkOutput("w1_data", 32'(data_out_b), 32'({2'(seqW[i-1]), 10'(seqW[i-1] + 5)}));
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
